cdb_arbiter: RTL and testbench

Sits between the add/multiply functional-unit result buffers and the single common data bus (CDB). Each FU result source has its own small FIFO. One result per cycle is granted onto the CDB, using round-robin arbitration, and is broadcast to the reservation stations and the register status table. Valid/ready handshakes give FU back-pressure when a queue fills.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/cdb_arbiter_if.sv | 47 ++++
 rtl/cdb_fifo.sv | 79 +++++++
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB). The reservation stations,
// the register status table and the CDB arbiter all import this package.
//   CDB_TAG_W / CDB_DATA_W : default reservation-station tag and result widths
//   cdb_src_e              : which functional unit produced a broadcast
//   cdb_entry_t            : one queued result record {data, tag}
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } cdb_src_e;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_TAG_W-1:0]  tag;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the two functional-unit result handshakes and the CDB broadcast.
//   add_valid/add_tag/add_data -> add_ready   : add FU result handshake
//   mul_valid/mul_tag/mul_data -> mul_ready   : mul FU result handshake
//   cdb_valid/cdb_tag/cdb_data/cdb_src        : registered CDB broadcast
// Modports:
//   master : functional-unit / consumer side (drives results, sees the CDB)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) ();

    logic              add_valid;
    logic [TAG_W-1:0]  add_tag;
    logic [DATA_W-1:0] add_data;
    logic              add_ready;

    logic              mul_valid;
    logic [TAG_W-1:0]  mul_tag;
    logic [DATA_W-1:0] mul_data;
    logic              mul_ready;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    cdb_src_e          cdb_src;

    modport master (
        output add_valid, add_tag, add_data,
        output mul_valid, mul_tag, mul_data,
        input  add_ready, mul_ready,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  add_valid, add_tag, add_data,
        input  mul_valid, mul_tag, mul_data,
        output add_ready, mul_ready,
        output cdb_valid, cdb_tag, cdb_data, cdb_src
    );

endinterface

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Synchronous FIFO holding results waiting for the CDB. Pointers wrap
// modulo DEPTH (power of two, >= 2); occupancy is a registered count.
//   clk, reset        : clock, asynchronous active-low reset
//   push_i, data_i    : write data_i at the tail (ignored when full)
//   pop_i             : drop the head entry (ignored when empty)
//   data_o            : current head entry (meaningful only when !empty_o)
//   full_o, empty_o   : occupancy flags decoded from the registered count
// -----------------------------------------------------------------------------
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop cancel out in the count.
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, because empty_o gates every pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Queues add and mul functional-unit results in one FIFO each and grants one
// head per cycle onto the registered common data bus.
//   clk, reset   : clock, asynchronous active-low reset
//   bus (slave)  : add/mul valid-ready result inputs, CDB broadcast outputs
// Arbitration is round-robin between the two non-empty queues (add wins the
// first tie after reset). Defining CDB_MUL_PRIORITY_EN switches to fixed
// priority: mul whenever its queue is non-empty, add only otherwise.
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam int ENTRY_W = TAG_W + DATA_W;

    logic               ready_en_q;
    logic               add_ready, mul_ready;
    logic               add_push, mul_push;
    logic               add_pop, mul_pop;
    logic               add_full, add_empty;
    logic               mul_full, mul_empty;
    logic [ENTRY_W-1:0] add_head, mul_head, grant_entry;

    logic               grant_valid;
    cdb_src_e           grant_src;
    cdb_src_e           last_grant_q, last_grant_d;

    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    cdb_src_e           cdb_src_q, cdb_src_d;

    // Ready is built from registered state only: an enable that sets on the
    // first edge out of reset, and each queue's registered full flag.
    assign add_ready = ready_en_q && !add_full;
    assign mul_ready = ready_en_q && !mul_full;
    assign add_push  = bus.add_valid && add_ready;
    assign mul_push  = bus.mul_valid && mul_ready;

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_add_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (add_push),
        .data_i  ({bus.add_data, bus.add_tag}),
        .pop_i   (add_pop),
        .data_o  (add_head),
        .full_o  (add_full),
        .empty_o (add_empty)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mul_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (mul_push),
        .data_i  ({bus.mul_data, bus.mul_tag}),
        .pop_i   (mul_pop),
        .data_o  (mul_head),
        .full_o  (mul_full),
        .empty_o (mul_empty)
    );

    // Grant decision looks only at registered FIFO state, so an entry pushed
    // this edge competes from the next cycle on (no bypass).
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_ADD;
`ifdef CDB_MUL_PRIORITY_EN
        if (!mul_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_MUL;
        end else if (!add_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_ADD;
        end
`else
        if (!add_empty && !mul_empty) begin
            grant_valid = 1'b1;
            grant_src   = (last_grant_q == SRC_MUL) ? SRC_ADD : SRC_MUL;
        end else if (!add_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_ADD;
        end else if (!mul_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_MUL;
        end
`endif
        add_pop      = grant_valid && (grant_src == SRC_ADD);
        mul_pop      = grant_valid && (grant_src == SRC_MUL);
        last_grant_d = grant_valid ? grant_src : last_grant_q;

        // The bus is zeroed rather than left holding a stale broadcast.
        grant_entry  = (grant_src == SRC_MUL) ? mul_head : add_head;
        cdb_valid_d  = grant_valid;
        cdb_tag_d    = grant_valid ? grant_entry[TAG_W-1:0] : '0;
        cdb_data_d   = grant_valid ? grant_entry[ENTRY_W-1:TAG_W] : '0;
        cdb_src_d    = grant_valid ? grant_src : SRC_ADD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q   <= 1'b0;
            last_grant_q <= SRC_MUL;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= SRC_ADD;
        end else begin
            ready_en_q   <= 1'b1;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign bus.add_ready = add_ready;
    assign bus.mul_ready = mul_ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Bench for cdb_arbiter. Each functional unit is modelled as a list of results
// it wants to deliver, presented in order and held until accepted. The
// reference keeps the two result queues as plain SV queues and applies the
// grant rule to their sizes once per clock. Honours CDB_MUL_PRIORITY_EN.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) fu ();

    cdb_arbiter #(
        .DEPTH  (DEPTH),
        .TAG_W  (CDB_TAG_W),
        .DATA_W (CDB_DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fu)
    );

    int n_vec = 0;
    int n_err = 0;

    // Results each FU still has to deliver (head is on the bus now).
    cdb_entry_t p_add[$];
    cdb_entry_t p_mul[$];
    // Reference view of what is queued inside the arbiter.
    cdb_entry_t m_add[$];
    cdb_entry_t m_mul[$];
    bit         started;
    cdb_src_e   m_last;
    bit         exp_valid;
    cdb_entry_t exp_entry;
    cdb_src_e   exp_src;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic cdb_entry_t mk(input int tag, input int data);
        cdb_entry_t e;
        e.tag  = CDB_TAG_W'(tag);
        e.data = CDB_DATA_W'(data);
        return e;
    endfunction

    task automatic drive();
        fu.add_valid = (p_add.size() != 0);
        fu.add_tag   = (p_add.size() != 0) ? p_add[0].tag  : '0;
        fu.add_data  = (p_add.size() != 0) ? p_add[0].data : '0;
        fu.mul_valid = (p_mul.size() != 0);
        fu.mul_tag   = (p_mul.size() != 0) ? p_mul[0].tag  : '0;
        fu.mul_data  = (p_mul.size() != 0) ? p_mul[0].data : '0;
    endtask

    task automatic compare();
        check("add_ready", fu.add_ready, started && (m_add.size() < DEPTH));
        check("mul_ready", fu.mul_ready, started && (m_mul.size() < DEPTH));
        check("cdb_valid", fu.cdb_valid, exp_valid);
        if (exp_valid) begin
            check("cdb_tag",  fu.cdb_tag,  exp_entry.tag);
            check("cdb_data", fu.cdb_data, exp_entry.data);
            check("cdb_src",  fu.cdb_src,  exp_src);
        end else begin
            check("idle_tag",  fu.cdb_tag,  0);
            check("idle_data", fu.cdb_data, 0);
        end
    endtask

    // One clock: present inputs, apply the reference rules to the pre-edge
    // queue contents, then compare once the edge has settled.
    task automatic tick();
        bit acc_a, acc_m, g_add, g_mul;
        drive();
        acc_a = started && (m_add.size() < DEPTH) && (p_add.size() != 0);
        acc_m = started && (m_mul.size() < DEPTH) && (p_mul.size() != 0);
        g_add = 1'b0;
        g_mul = 1'b0;
`ifdef CDB_MUL_PRIORITY_EN
        if (m_mul.size() != 0)      g_mul = 1'b1;
        else if (m_add.size() != 0) g_add = 1'b1;
`else
        if (m_add.size() != 0 && m_mul.size() != 0) begin
            if (m_last == SRC_MUL) g_add = 1'b1;
            else                   g_mul = 1'b1;
        end else if (m_add.size() != 0) begin
            g_add = 1'b1;
        end else if (m_mul.size() != 0) begin
            g_mul = 1'b1;
        end
`endif
        exp_valid = g_add || g_mul;
        if (g_add) begin
            exp_entry = m_add.pop_front();
            exp_src   = SRC_ADD;
            m_last    = SRC_ADD;
        end else if (g_mul) begin
            exp_entry = m_mul.pop_front();
            exp_src   = SRC_MUL;
            m_last    = SRC_MUL;
        end
        if (acc_a) m_add.push_back(p_add.pop_front());
        if (acc_m) m_mul.push_back(p_mul.pop_front());
        started = 1'b1;
        @(posedge clk);
        #1;
        compare();
    endtask

    // Assert reset between edges, hold it across one edge, release it between
    // edges; ready must stay low until the first edge after release.
    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1;
        check("rst_cdb_valid", fu.cdb_valid, 0);
        check("rst_cdb_tag",   fu.cdb_tag,   0);
        check("rst_cdb_data",  fu.cdb_data,  0);
        check("rst_cdb_src",   fu.cdb_src,   0);
        check("rst_add_ready", fu.add_ready, 0);
        check("rst_mul_ready", fu.mul_ready, 0);
        m_add.delete();
        m_mul.delete();
        p_add.delete();
        p_mul.delete();
        started   = 1'b0;
        m_last    = SRC_MUL;
        exp_valid = 1'b0;
        drive();
        @(posedge clk);
        #1;
        check("rst_hold_valid", fu.cdb_valid, 0);
        #2 reset = 1'b1;
        #1;
        check("rel_add_ready", fu.add_ready, 0);
        check("rel_mul_ready", fu.mul_ready, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (p_add.size() != 0 || p_mul.size() != 0 ||
                m_add.size() != 0 || m_mul.size() != 0) begin
                tick();
            end
        end
        check("drained", m_add.size() + m_mul.size() + p_add.size() + p_mul.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        int rate_a[4] = '{20, 60, 100, 90};
        int rate_m[4] = '{70, 30, 100, 50};
        cdb_entry_t e;

        reset = 1'b1;
        drive();
        #1;
        reset_pulse();
        tick();

        // Single add result: broadcast for exactly one cycle, two edges later.
        p_add.push_back(mk(3, 'h11));
        repeat (4) tick();

        // Contention: add tag 1 and mul tag 9 pushed together three times.
        repeat (3) begin
            p_add.push_back(mk(1, 'h100));
            p_mul.push_back(mk(9, 'h900));
        end
        drain();

        // Fill: mul tags 1..6 held valid while add pushes every cycle.
        for (int i = 1; i <= 6; i++) p_mul.push_back(mk(i, 'h5000 + i));
        for (int i = 0; i < 10; i++) p_add.push_back(mk(i, 'hA000 + i));
        drain();

        // Pointer wrap: ten add results, one every other cycle; tag 0 included.
        for (int i = 0; i < 10; i++) begin
            p_add.push_back(mk(i, 'hC0DE0000 + i));
            repeat (2) tick();
        end
        drain();

        // Reset in the middle of traffic discards everything queued.
        repeat (3) begin
            p_add.push_back(mk(5, 'h55));
            p_mul.push_back(mk(6, 'h66));
        end
        repeat (3) tick();
        reset_pulse();
        repeat (6) tick();

        // Randomised traffic at several load levels.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 100; c++) begin
                if (p_add.size() == 0 && $urandom_range(99) < rate_a[ph]) begin
                    e.tag  = CDB_TAG_W'($urandom);
                    e.data = $urandom;
                    p_add.push_back(e);
                end
                if (p_mul.size() == 0 && $urandom_range(99) < rate_m[ph]) begin
                    e.tag  = CDB_TAG_W'($urandom);
                    e.data = $urandom;
                    p_mul.push_back(e);
                end
                tick();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
